// File: rtl/datapath_pkg.sv
// Shared constants for the datapath selection primitives.
// Select encodings are used by the wrapper muxes built on mux4_1.
package datapath_pkg;
  localparam int GATE_DELAY = 50;
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;
endpackage

// File: rtl/D_FF.sv
// D flip-flop with synchronous active-high clear.
// Used for the stage-boundary copy of the mux output.
module D_FF (
  output logic q,
  input  logic d,
  input  logic reset,
  input  logic clk
);
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

// File: rtl/mux2_1.sv
// Gate-level 2:1 mux; a deselected input is masked by the AND.
// An X on the deselected input therefore never reaches out.
module mux2_1 (
  output logic out,
  input  logic i0,
  input  logic i1,
  input  logic sel
);
  assign out = (~sel & i0) | (sel & i1);
endmodule

// File: rtl/mux4_1.sv
// Single-bit 4:1 mux as a two-level tree of 2:1 muxes.
// out stays live through reset; only out_q is cleared.
module mux4_1
  import datapath_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out,
  output logic       out_q
);
  logic m0;
  logic m1;

  mux2_1 u_lo (
    .out (m0),
    .i0  (in[0]),
    .i1  (in[1]),
    .sel (sel[0])
  );

  mux2_1 u_hi (
    .out (m1),
    .i0  (in[2]),
    .i1  (in[3]),
    .sel (sel[0])
  );

  mux2_1 u_top (
    .out (out),
    .i0  (m0),
    .i1  (m1),
    .sel (sel[1])
  );

  D_FF u_q (
    .q     (out_q),
    .d     (out),
    .reset (reset),
    .clk   (clk)
  );
endmodule

// File: tb/tb_mux4_1.sv
// Directed bench for mux4_1: comb select, isolation, register path.
`timescale 1ps/1ps
module tb_mux4_1;
  import datapath_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic [1:0] sel;
  logic       out;
  logic       out_q;

  int checks;
  int errors;

  mux4_1 dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #1000 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    din = 4'b1111;
    sel = SEL_D;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_q got %b want 0", out_q);
    end
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb got %b want 1", out);
    end
  endtask

  task automatic test_directed();
    logic [1:0] sv [4];
    logic       ev [4];
    sv[0] = 2'b10; ev[0] = 1'b1;
    sv[1] = 2'b00; ev[1] = 1'b0;
    sv[2] = 2'b01; ev[2] = 1'b1;
    sv[3] = 2'b11; ev[3] = 1'b0;
    din = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      sel = sv[k];
      #500;
      checks++;
      if (out !== ev[k]) begin
        errors++;
        $display("FAIL directed sel=%b got %b want %b",
                 sv[k], out, ev[k]);
      end
    end
  endtask

  task automatic test_sweep();
    logic e;
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < 4; s++) begin
        din = i[3:0];
        sel = s[1:0];
        e = i[s];
        #500;
        checks++;
        if (out !== e) begin
          errors++;
          $display("FAIL sweep in=%b sel=%0d got %b want %b",
                   i[3:0], s, out, e);
        end
      end
    end
  endtask

  task automatic test_isolation();
    sel = SEL_B;
    din = 4'bxx1x;
    #500;
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL isolation_b got %b want 1", out);
    end
    sel = SEL_C;
    din = 4'bx0xx;
    #500;
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL isolation_c got %b want 0", out);
    end
  endtask

  task automatic test_register();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_q !== 1'b0) begin
      errors++;
      $display("FAIL reg_reset got %b want 0", out_q);
    end
    reset = 1'b0;
    din = 4'b1000;
    sel = SEL_D;
    @(negedge clk);
    checks++;
    if (out_q !== 1'b1) begin
      errors++;
      $display("FAIL reg_load1 got %b want 1", out_q);
    end
    sel = SEL_A;
    #500;
    checks++;
    if (out_q !== 1'b1) begin
      errors++;
      $display("FAIL reg_hold got %b want 1", out_q);
    end
    @(negedge clk);
    checks++;
    if (out_q !== 1'b0) begin
      errors++;
      $display("FAIL reg_load0 got %b want 0", out_q);
    end
  endtask

  task automatic test_midrun_reset();
    din = 4'b1000;
    sel = SEL_D;
    @(negedge clk);
    checks++;
    if (out_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %b want 1", out_q);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_q !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear got %b want 0", out_q);
    end
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL mid_comb got %b want 1", out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_release got %b want 1", out_q);
    end
  endtask

  task automatic test_timing();
    din = 4'b1000;
    sel = SEL_A;
    #500;
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL timing_pre got %b want 0", out);
    end
    sel = SEL_D;
    #200;
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (out !== 1'b1) begin
        errors++;
        $display("FAIL timing_settle t=%0d got %b want 1", t, out);
      end
      #100;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    din = 4'b0000;
    sel = 2'b00;
    test_reset();
    reset = 1'b0;
    test_directed();
    test_sweep();
    test_isolation();
    test_register();
    test_midrun_reset();
    test_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
